// File: rtl/cv32e40p_popcnt_seq_if.sv
// Command / data / result channels of the multi-word popcount sequencer.
// Every channel is valid/ready: a transfer happens on a rising clk edge where both are high.
interface cv32e40p_popcnt_seq_if #(
    parameter int unsigned MAX_WORDS = 4
);
    localparam int unsigned LEN_W = $clog2(MAX_WORDS + 1);
    localparam int unsigned CNT_W = $clog2(32 * MAX_WORDS + 1);

    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic [LEN_W-1:0] cmd_len_i;
    logic             data_valid_i;
    logic             data_ready_o;
    logic [31:0]      data_i;
    logic             abort_i;
    logic             res_valid_o;
    logic             res_ready_i;
    logic [CNT_W-1:0] res_count_o;
    logic             res_parity_o;
    logic             busy_o;
    logic [1:0]       state_dbg_o;

    modport slave (
        input  cmd_valid_i, cmd_len_i, data_valid_i, data_i, abort_i, res_ready_i,
        output cmd_ready_o, data_ready_o, res_valid_o, res_count_o, res_parity_o,
               busy_o, state_dbg_o
    );

    modport master (
        output cmd_valid_i, cmd_len_i, data_valid_i, data_i, abort_i, res_ready_i,
        input  cmd_ready_o, data_ready_o, res_valid_o, res_count_o, res_parity_o,
               busy_o, state_dbg_o
    );
endinterface

// File: rtl/cv32e40p_popcnt_seq.sv
// Multi-word popcount sequencer sharing one 32-bit popcount datapath.
// Define CV32E40P_POPCNT_SEQ_PIPE_EN to register the per-word count before accumulation.
module cv32e40p_popcnt_seq #(
    parameter int unsigned MAX_WORDS = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    cv32e40p_popcnt_seq_if.slave   bus
);
    localparam int unsigned LEN_W = $clog2(MAX_WORDS + 1);
    localparam int unsigned CNT_W = $clog2(32 * MAX_WORDS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] words_left_q, words_left_d;
    logic [5:0]       word_cnt;
    logic [LEN_W-1:0] len_clamped;
    logic             data_hs;
    logic             cmd_ready;
    logic             data_ready;
    logic             res_valid;

`ifdef CV32E40P_POPCNT_SEQ_PIPE_EN
    logic [5:0] pipe_cnt_q, pipe_cnt_d;
    logic       pipe_vld_q, pipe_vld_d;
`endif

    always_comb begin
        word_cnt = '0;
        for (int i = 0; i < 32; i++) begin
            word_cnt = word_cnt + {5'd0, bus.data_i[i]};
        end
    end

    assign len_clamped = (bus.cmd_len_i > LEN_W'(MAX_WORDS)) ? LEN_W'(MAX_WORDS) : bus.cmd_len_i;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        words_left_d = words_left_q;
        cmd_ready    = 1'b0;
        data_ready   = 1'b0;
        res_valid    = 1'b0;
        data_hs      = 1'b0;
`ifdef CV32E40P_POPCNT_SEQ_PIPE_EN
        pipe_cnt_d   = pipe_cnt_q;
        pipe_vld_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid_i) begin
                    words_left_d = len_clamped;
                    acc_d        = '0;
                    state_d      = (len_clamped == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                // words_left reaches zero in ACCUM only while the pipeline drains
                data_ready = (words_left_q != '0);
                data_hs    = data_ready && bus.data_valid_i;
`ifdef CV32E40P_POPCNT_SEQ_PIPE_EN
                if (pipe_vld_q) begin
                    acc_d = acc_q + CNT_W'(pipe_cnt_q);
                end
                if (data_hs) begin
                    pipe_cnt_d   = word_cnt;
                    pipe_vld_d   = 1'b1;
                    words_left_d = words_left_q - LEN_W'(1);
                end
                if (words_left_q == '0) begin
                    state_d = DONE;
                end
`else
                if (data_hs) begin
                    acc_d        = acc_q + CNT_W'(word_cnt);
                    words_left_d = words_left_q - LEN_W'(1);
                    if (words_left_q == LEN_W'(1)) begin
                        state_d = DONE;
                    end
                end
`endif
            end
            DONE: begin
                res_valid = 1'b1;
                if (bus.res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides everything, including a word accepted this cycle.
        if (bus.abort_i && (state_q != IDLE)) begin
            state_d      = IDLE;
            acc_d        = '0;
            words_left_d = '0;
`ifdef CV32E40P_POPCNT_SEQ_PIPE_EN
            pipe_cnt_d   = '0;
            pipe_vld_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            words_left_q <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            words_left_q <= words_left_d;
        end
    end

`ifdef CV32E40P_POPCNT_SEQ_PIPE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_cnt_q <= '0;
            pipe_vld_q <= 1'b0;
        end else begin
            pipe_cnt_q <= pipe_cnt_d;
            pipe_vld_q <= pipe_vld_d;
        end
    end
`endif

    assign bus.cmd_ready_o  = cmd_ready;
    assign bus.data_ready_o = data_ready;
    assign bus.res_valid_o  = res_valid;
    assign bus.res_count_o  = acc_q;
    assign bus.res_parity_o = acc_q[0];
    assign bus.busy_o       = (state_q != IDLE);
    assign bus.state_dbg_o  = state_q;
endmodule

// File: tb/tb_cv32e40p_popcnt_seq.sv
// Bench for cv32e40p_popcnt_seq: directed scenarios plus randomized commands
// checked against a sum-of-$countones reference over the streamed words.
module tb_cv32e40p_popcnt_seq;
    localparam int MAX_WORDS = 4;
    localparam int LEN_W     = $clog2(MAX_WORDS + 1);
    localparam int CNT_W     = $clog2(32 * MAX_WORDS + 1);
`ifdef CV32E40P_POPCNT_SEQ_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int TIMEOUT = 50;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    cv32e40p_popcnt_seq_if #(.MAX_WORDS(MAX_WORDS)) bus ();
    cv32e40p_popcnt_seq #(.MAX_WORDS(MAX_WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int               total = 0;
    int               bad   = 0;
    logic [CNT_W-1:0] exp_q[$];
    logic [31:0]      wq[$];

    // ---------------- clock / drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.cmd_valid_i  = 1'b0;
        bus.cmd_len_i    = '0;
        bus.data_valid_i = 1'b0;
        bus.data_i       = '0;
        bus.abort_i      = 1'b0;
        bus.res_ready_i  = 1'b0;
    endtask

    task automatic drive_cmd(input int len, output bit to);
        int n = 0;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_len_i   = LEN_W'(len);
        while (!bus.cmd_ready_o && n < TIMEOUT) begin
            step();
            n++;
        end
        to = (n >= TIMEOUT);
        step();
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic drive_word(input logic [31:0] w, input int gap, output bit to);
        int n = 0;
        repeat (gap) step();
        bus.data_valid_i = 1'b1;
        bus.data_i       = w;
        while (!bus.data_ready_o && n < TIMEOUT) begin
            step();
            n++;
        end
        to = (n >= TIMEOUT);
        step();
        bus.data_valid_i = 1'b0;
    endtask

    // reference: total ones over the words the command will actually consume
    function automatic logic [CNT_W-1:0] model_sum(input int len);
        int s = 0;
        int nw = (len > MAX_WORDS) ? MAX_WORDS : len;
        for (int i = 0; i < nw; i++) s += $countones(wq[i]);
        return CNT_W'(s);
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) step();
        total++; if (bus.cmd_ready_o !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready_o); end
        total++; if (bus.res_valid_o !== 1'b0) begin bad++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid_o); end
        total++; if (bus.data_ready_o !== 1'b0) begin bad++; $display("FAIL reset_data_ready: got %b want 0", bus.data_ready_o); end
        total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
        total++; if (bus.res_count_o !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", bus.res_count_o); end
        total++; if (bus.res_parity_o !== 1'b0) begin bad++; $display("FAIL reset_parity: got %b want 0", bus.res_parity_o); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        total++; if (bus.cmd_ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin bad++; $display("FAIL reset_release: got ready=%b busy=%b want 1/0", bus.cmd_ready_o, bus.busy_o); end
    endtask

    task automatic test_basic();
        bit to;
        logic [CNT_W-1:0] exp;
        wq = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0001};
        exp_q.push_back(model_sum(3));
        drive_cmd(3, to);
        total++; if (to) begin bad++; $display("FAIL basic_cmd_timeout: got timeout want accept"); end
        for (int i = 0; i < 3; i++) begin
            drive_word(wq[i], 0, to);
            total++; if (to) begin bad++; $display("FAIL basic_word_timeout: word %0d got timeout want accept", i); end
        end
        for (int k = 1; k < LAT; k++) begin
            total++; if (bus.res_valid_o !== 1'b0) begin bad++; $display("FAIL basic_early_valid: got %b want 0", bus.res_valid_o); end
            step();
        end
        total++; if (bus.res_valid_o !== 1'b1) begin bad++; $display("FAIL basic_latency: got valid=%b want 1", bus.res_valid_o); end
        exp = exp_q.pop_front();
        total++; if (bus.res_count_o !== exp) begin bad++; $display("FAIL basic_count: got %0d want %0d", bus.res_count_o, exp); end
        total++; if (bus.res_count_o !== CNT_W'(34)) begin bad++; $display("FAIL basic_count34: got %0d want 34", bus.res_count_o); end
        total++; if (bus.res_parity_o !== 1'b0) begin bad++; $display("FAIL basic_parity: got %b want 0", bus.res_parity_o); end
        bus.res_ready_i = 1'b1;
        step();
        bus.res_ready_i = 1'b0;
        total++; if (bus.res_valid_o !== 1'b0 || bus.cmd_ready_o !== 1'b1) begin bad++; $display("FAIL basic_after_hs: got valid=%b ready=%b want 0/1", bus.res_valid_o, bus.cmd_ready_o); end
    endtask

    task automatic test_zero_len();
        bit to;
        drive_cmd(0, to);
        total++; if (to) begin bad++; $display("FAIL zero_cmd_timeout: got timeout want accept"); end
        total++; if (bus.res_valid_o !== 1'b1) begin bad++; $display("FAIL zero_latency: got valid=%b want 1", bus.res_valid_o); end
        total++; if (bus.res_count_o !== '0) begin bad++; $display("FAIL zero_count: got %0d want 0", bus.res_count_o); end
        total++; if (bus.data_ready_o !== 1'b0) begin bad++; $display("FAIL zero_data_ready: got %b want 0", bus.data_ready_o); end
        bus.res_ready_i = 1'b1;
        step();
        bus.res_ready_i = 1'b0;
    endtask

    task automatic test_gaps();
        bit to;
        logic [CNT_W-1:0] exp;
        wq = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        exp_q.push_back(model_sum(MAX_WORDS));
        drive_cmd(MAX_WORDS, to);
        for (int i = 0; i < MAX_WORDS; i++) begin
            drive_word(wq[i], $urandom_range(0, 3), to);
            total++; if (to) begin bad++; $display("FAIL gaps_word_timeout: word %0d got timeout want accept", i); end
        end
        repeat (LAT - 1) step();
        exp = exp_q.pop_front();
        total++; if (bus.res_valid_o !== 1'b1) begin bad++; $display("FAIL gaps_valid: got %b want 1", bus.res_valid_o); end
        total++; if (bus.res_count_o !== exp || exp !== CNT_W'(128)) begin bad++; $display("FAIL gaps_count: got %0d want %0d", bus.res_count_o, exp); end
        bus.res_ready_i = 1'b1;
        step();
        bus.res_ready_i = 1'b0;
    endtask

    task automatic test_abort();
        bit to;
        logic [CNT_W-1:0] exp;
        drive_cmd(2, to);
        drive_word(32'h0000_000F, 0, to);
        bus.data_valid_i = 1'b1;
        bus.data_i       = 32'hFFFF_0000;
        bus.abort_i      = 1'b1;
        step();
        bus.data_valid_i = 1'b0;
        bus.abort_i      = 1'b0;
        total++; if (bus.cmd_ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin bad++; $display("FAIL abort_idle: got ready=%b busy=%b want 1/0", bus.cmd_ready_o, bus.busy_o); end
        for (int k = 0; k < 3; k++) begin
            total++; if (bus.res_valid_o !== 1'b0) begin bad++; $display("FAIL abort_no_result: cycle %0d got valid=%b want 0", k, bus.res_valid_o); end
            step();
        end
        wq = '{32'h0000_0003};
        exp_q.push_back(model_sum(1));
        drive_cmd(1, to);
        drive_word(wq[0], 0, to);
        repeat (LAT - 1) step();
        exp = exp_q.pop_front();
        total++; if (bus.res_valid_o !== 1'b1 || bus.res_count_o !== exp) begin bad++; $display("FAIL abort_next_cmd: got valid=%b count=%0d want 1/%0d", bus.res_valid_o, bus.res_count_o, exp); end
        // abort while holding a result
        bus.abort_i = 1'b1;
        step();
        bus.abort_i = 1'b0;
        total++; if (bus.res_valid_o !== 1'b0 || bus.cmd_ready_o !== 1'b1) begin bad++; $display("FAIL abort_done: got valid=%b ready=%b want 0/1", bus.res_valid_o, bus.cmd_ready_o); end
        total++; if (bus.res_count_o !== '0) begin bad++; $display("FAIL abort_acc_clear: got %0d want 0", bus.res_count_o); end
        // abort in IDLE is ignored: a command presented with it is accepted
        bus.abort_i = 1'b1;
        drive_cmd(0, to);
        bus.abort_i = 1'b0;
        total++; if (bus.res_valid_o !== 1'b1) begin bad++; $display("FAIL abort_idle_ignored: got valid=%b want 1", bus.res_valid_o); end
        bus.res_ready_i = 1'b1;
        step();
        bus.res_ready_i = 1'b0;
    endtask

    task automatic test_backpressure();
        bit to;
        logic [CNT_W-1:0] exp;
        wq = '{32'h1234_5678, 32'hF0F0_F0F0};
        exp_q.push_back(model_sum(2));
        drive_cmd(2, to);
        drive_word(wq[0], 0, to);
        drive_word(wq[1], 0, to);
        repeat (LAT - 1) step();
        exp = exp_q.pop_front();
        bus.cmd_valid_i = 1'b1;
        bus.cmd_len_i   = LEN_W'(1);
        for (int k = 0; k < 5; k++) begin
            total++; if (bus.res_valid_o !== 1'b1 || bus.res_count_o !== exp) begin bad++; $display("FAIL bp_hold: cycle %0d got valid=%b count=%0d want 1/%0d", k, bus.res_valid_o, bus.res_count_o, exp); end
            total++; if (bus.cmd_ready_o !== 1'b0 || bus.res_parity_o !== exp[0]) begin bad++; $display("FAIL bp_cmd_blocked: got ready=%b parity=%b want 0/%b", bus.cmd_ready_o, bus.res_parity_o, exp[0]); end
            step();
        end
        bus.res_ready_i = 1'b1;
        step();
        bus.res_ready_i = 1'b0;
        total++; if (bus.busy_o !== 1'b0 || bus.cmd_ready_o !== 1'b1) begin bad++; $display("FAIL bp_no_same_cycle_cmd: got busy=%b ready=%b want 0/1", bus.busy_o, bus.cmd_ready_o); end
        step();
        bus.cmd_valid_i = 1'b0;
        total++; if (bus.busy_o !== 1'b1) begin bad++; $display("FAIL bp_cmd_next_cycle: got busy=%b want 1", bus.busy_o); end
        wq = '{32'h0000_0003};
        exp_q.push_back(model_sum(1));
        drive_word(wq[0], 0, to);
        repeat (LAT - 1) step();
        exp = exp_q.pop_front();
        total++; if (bus.res_valid_o !== 1'b1 || bus.res_count_o !== exp) begin bad++; $display("FAIL bp_followup: got valid=%b count=%0d want 1/%0d", bus.res_valid_o, bus.res_count_o, exp); end
        bus.res_ready_i = 1'b1;
        step();
        bus.res_ready_i = 1'b0;
    endtask

    task automatic test_async_reset();
        bit to;
        logic [CNT_W-1:0] exp;
        drive_cmd(4, to);
        drive_word(32'hFFFF_FFFF, 0, to);
        drive_word(32'h0F0F_0F0F, 0, to);
        bus.data_valid_i = 1'b1;
        bus.data_i       = 32'hFFFF_FFFF;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.cmd_ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin bad++; $display("FAIL areset_state: got ready=%b busy=%b want 1/0", bus.cmd_ready_o, bus.busy_o); end
        total++; if (bus.res_valid_o !== 1'b0 || bus.data_ready_o !== 1'b0) begin bad++; $display("FAIL areset_outs: got valid=%b dready=%b want 0/0", bus.res_valid_o, bus.data_ready_o); end
        total++; if (bus.res_count_o !== '0 || bus.res_parity_o !== 1'b0) begin bad++; $display("FAIL areset_count: got %0d/%b want 0/0", bus.res_count_o, bus.res_parity_o); end
        bus.data_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            total++; if (bus.res_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin bad++; $display("FAIL areset_stale: cycle %0d got valid=%b busy=%b want 0/0", k, bus.res_valid_o, bus.busy_o); end
        end
        wq = '{32'hA5A5_A5A5};
        exp_q.push_back(model_sum(1));
        drive_cmd(1, to);
        drive_word(wq[0], 0, to);
        repeat (LAT - 1) step();
        exp = exp_q.pop_front();
        total++; if (bus.res_valid_o !== 1'b1 || bus.res_count_o !== exp) begin bad++; $display("FAIL areset_recover: got valid=%b count=%0d want 1/%0d", bus.res_valid_o, bus.res_count_o, exp); end
        bus.res_ready_i = 1'b1;
        step();
        bus.res_ready_i = 1'b0;
    endtask

    task automatic test_random();
        bit to;
        int len, nw, hold, n;
        logic [CNT_W-1:0] exp;
        for (int t = 0; t < 20; t++) begin
            len = $urandom_range(0, (1 << LEN_W) - 1);
            nw  = (len > MAX_WORDS) ? MAX_WORDS : len;
            wq.delete();
            for (int i = 0; i < nw; i++) begin
                case ($urandom_range(0, 3))
                    0:       wq.push_back(32'hFFFF_FFFF);
                    1:       wq.push_back(32'h0000_0000);
                    default: wq.push_back($urandom);
                endcase
            end
            exp_q.push_back(model_sum(len));
            drive_cmd(len, to);
            total++; if (to) begin bad++; $display("FAIL rand_cmd_timeout: txn %0d got timeout want accept", t); end
            for (int i = 0; i < nw; i++) begin
                drive_word(wq[i], $urandom_range(0, 2), to);
            end
            n = 0;
            while (!bus.res_valid_o && n < TIMEOUT) begin
                step();
                n++;
            end
            exp = exp_q.pop_front();
            total++; if (n != ((nw == 0) ? 0 : LAT - 1)) begin bad++; $display("FAIL rand_latency: txn %0d len %0d got extra=%0d want %0d", t, len, n, (nw == 0) ? 0 : LAT - 1); end
            hold = $urandom_range(0, 3);
            for (int k = 0; k <= hold; k++) begin
                total++; if (bus.res_valid_o !== 1'b1 || bus.res_count_o !== exp || bus.res_parity_o !== exp[0]) begin bad++; $display("FAIL rand_result: txn %0d len %0d got valid=%b count=%0d want 1/%0d", t, len, bus.res_valid_o, bus.res_count_o, exp); end
                if (k == hold) bus.res_ready_i = 1'b1;
                step();
            end
            bus.res_ready_i = 1'b0;
            total++; if (bus.res_valid_o !== 1'b0) begin bad++; $display("FAIL rand_release: txn %0d got valid=%b want 0", t, bus.res_valid_o); end
        end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_basic();
        test_zero_len();
        test_gaps();
        test_abort();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish");
        $fatal(1, "watchdog expired");
    end
endmodule
